// File: rtl/q2_serial_pattern_gen_if.sv
// Request and serial-stream bundle for q2_serial_pattern_gen.
// The master modport is the pattern requester / w consumer; the slave modport is the generator.
interface q2_serial_pattern_gen_if #(
    parameter int PATTERN_W = 8,
    parameter int LEN_W     = 4,
    parameter int REP_W     = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PATTERN_W-1:0] in_data;
    logic [LEN_W-1:0]     in_len;
    logic [REP_W-1:0]     in_repeat;
    logic                 w;
    logic                 w_valid;
    logic                 busy;
    logic                 done;

    modport master (
        output in_valid,
        output in_data,
        output in_len,
        output in_repeat,
        input  in_ready,
        input  w,
        input  w_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_len,
        input  in_repeat,
        output in_ready,
        output w,
        output w_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/q2_serial_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first on w,
// replaying it in_repeat extra times with a fixed idle gap between passes.
module q2_serial_pattern_gen #(
    parameter int PATTERN_W  = 8,
    parameter int LEN_W      = 4,
    parameter int REP_W      = 4,
    parameter int GAP_CYCLES = 2,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    q2_serial_pattern_gen_if.slave pg
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PATTERN_W);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [PATTERN_W-1:0] data_r;
    logic [PATTERN_W-1:0] data_next_s;
    logic [LEN_W-1:0]     len_r;
    logic [LEN_W-1:0]     len_next_s;
    logic [LEN_W-1:0]     idx_r;
    logic [LEN_W-1:0]     idx_next_s;
    logic [REP_W-1:0]     rep_r;
    logic [REP_W-1:0]     rep_next_s;
    logic [GAP_W-1:0]     gap_r;
    logic [GAP_W-1:0]     gap_next_s;

    logic                 accept_s;
    logic [LEN_W-1:0]     len_clamped_s;
    logic [PATTERN_W-1:0] shifted_s;

    logic                 w_r;
    logic                 w_valid_r;
    logic                 done_r;
    logic                 w_next_s;
    logic                 w_valid_next_s;
    logic                 done_next_s;
    logic                 in_ready_s;
    logic                 busy_s;

    // Request qualification and length clamp (0 or oversize means full width).
    always_comb begin
        accept_s = pg.in_valid && (state_r == ST_IDLE);
        if ((pg.in_len == '0) || (pg.in_len > LEN_MAX)) begin
            len_clamped_s = LEN_MAX;
        end else begin
            len_clamped_s = pg.in_len;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_next_s = state_r;
        data_next_s  = data_r;
        len_next_s   = len_r;
        idx_next_s   = idx_r;
        rep_next_s   = rep_r;
        gap_next_s   = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_SHIFT;
                    data_next_s  = pg.in_data;
                    len_next_s   = len_clamped_s;
                    idx_next_s   = len_clamped_s - LEN_W'(1);
                    rep_next_s   = pg.in_repeat;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (idx_r != '0) begin
                    idx_next_s = idx_r - LEN_W'(1);
                end else if (rep_r != '0) begin
                    rep_next_s = rep_r - REP_W'(1);
                    idx_next_s = len_r - LEN_W'(1);
                    if (GAP_CYCLES > 0) begin
                        state_next_s = ST_GAP;
                        gap_next_s   = GAP_LOAD;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_r == '0) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    gap_next_s = gap_r - GAP_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Latched request, bit index, repeat and gap counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= '0;
            len_r  <= '0;
            idx_r  <= '0;
            rep_r  <= '0;
            gap_r  <= '0;
        end else begin
            data_r <= data_next_s;
            len_r  <= len_next_s;
            idx_r  <= idx_next_s;
            rep_r  <= rep_next_s;
            gap_r  <= gap_next_s;
        end
    end

    // Output decode: w/w_valid/done precomputed from the next state so the flops line up with it.
    always_comb begin
        in_ready_s     = (state_r == ST_IDLE);
        busy_s         = (state_r == ST_SHIFT) || (state_r == ST_GAP);
        shifted_s      = data_next_s >> idx_next_s;
        w_valid_next_s = (state_next_s == ST_SHIFT);
        if (w_valid_next_s) begin
            w_next_s = shifted_s[0];
        end else begin
            w_next_s = IDLE_LEVEL;
        end
        done_next_s = (state_r == ST_SHIFT) && (idx_r == '0) && (rep_r == '0);
    end

    // Registered serial outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_r       <= IDLE_LEVEL;
            w_valid_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            w_r       <= w_next_s;
            w_valid_r <= w_valid_next_s;
            done_r    <= done_next_s;
        end
    end

    assign pg.w        = w_r;
    assign pg.w_valid  = w_valid_r;
    assign pg.done     = done_r;
    assign pg.in_ready = in_ready_s;
    assign pg.busy     = busy_s;

endmodule

// File: tb/tb_q2_serial_pattern_gen.sv
// Directed, table-driven bench for q2_serial_pattern_gen (default parameters, GAP_CYCLES=2).
// Expected streams are written per cycle after the accept edge: '1'/'0' = valid bit, '-' = gap cycle.
module tb_q2_serial_pattern_gen;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    q2_serial_pattern_gen_if #(.PATTERN_W(8), .LEN_W(4), .REP_W(4)) bus ();

    q2_serial_pattern_gen #(
        .PATTERN_W (8),
        .LEN_W     (4),
        .REP_W     (4),
        .GAP_CYCLES(2),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pg   (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [3:0] len;
        logic [3:0] rep;
        bit         noise;
        string      exp;
    } vec_t;

    vec_t vecs[8];

    // observed = {in_ready, w_valid, w, busy, done}
    localparam logic [4:0] EXP_ONE  = 5'b0_1_1_1_0;
    localparam logic [4:0] EXP_ZERO = 5'b0_1_0_1_0;
    localparam logic [4:0] EXP_GAP  = 5'b0_0_0_1_0;
    localparam logic [4:0] EXP_DONE = 5'b1_0_0_0_1;
    localparam logic [4:0] EXP_IDLE = 5'b1_0_0_0_0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] observed();
        return {bus.in_ready, bus.w_valid, bus.w, bus.busy, bus.done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = observed();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: {rdy,vld,w,busy,done} got %b required %b", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
        int waited;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 64) begin
            step();
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready got %b required 1", bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_len    = l;
        bus.in_repeat = r;
        step();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_len    = 4'd0;
        bus.in_repeat = 4'd0;
    endtask

    task automatic run_vec(input vec_t v);
        int  n;
        byte c;
        n = v.exp.len();
        send(v.data, v.len, v.rep);
        for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            c = v.exp[k];
            if (c == "-") chk($sformatf("%s c%0d", v.name, k + 1), EXP_GAP);
            else if (c == "1") chk($sformatf("%s c%0d", v.name, k + 1), EXP_ONE);
            else chk($sformatf("%s c%0d", v.name, k + 1), EXP_ZERO);
            if (v.noise && (k < n - 1)) begin
                bus.in_valid  = ((k % 2) == 0);
                bus.in_data   = 8'($urandom);
                bus.in_len    = 4'd3;
                bus.in_repeat = 4'd5;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        step();
        chk($sformatf("%s done", v.name), EXP_DONE);
        step();
        chk($sformatf("%s after", v.name), EXP_IDLE);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{"basic",     8'hBB, 4'd4,  4'd0, 1'b0, "1011"};
        vecs[1] = '{"rep_gap",   8'h05, 4'd3,  4'd2, 1'b0, "101--101--101"};
        vecs[2] = '{"len0",      8'hA5, 4'd0,  4'd0, 1'b0, "10100101"};
        vecs[3] = '{"len12",     8'hA5, 4'd12, 4'd0, 1'b0, "10100101"};
        vecs[4] = '{"len1_rep1", 8'h01, 4'd1,  4'd1, 1'b0, "1--1"};
        vecs[5] = '{"full_rep1", 8'h3C, 4'd8,  4'd1, 1'b0, "00111100--00111100"};
        vecs[6] = '{"len15",     8'hF0, 4'd15, 4'd0, 1'b0, "11110000"};
        vecs[7] = '{"busy_ign",  8'hA5, 4'd8,  4'd0, 1'b1, "10100101"};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_len    = 4'd0;
        bus.in_repeat = 4'd0;
        step();
        step();
        chk("reset_state", EXP_IDLE);
        reset = 1'b0;
        step();
        chk("post_reset", EXP_IDLE);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back: second request held valid across the done cycle of the first.
        send(8'hBB, 4'd4, 4'd0);
        chk("b2b c1", EXP_ONE);
        step(); chk("b2b c2", EXP_ZERO);
        step(); chk("b2b c3", EXP_ONE);
        step(); chk("b2b c4", EXP_ONE);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h81;
        bus.in_len    = 4'd1;
        bus.in_repeat = 4'd0;
        step(); chk("b2b done1", EXP_DONE);
        step();
        bus.in_valid = 1'b0;
        chk("b2b second bit", EXP_ONE);
        step(); chk("b2b done2", EXP_DONE);
        step(); chk("b2b idle", EXP_IDLE);

        // Asynchronous reset between edges during bit 3 of an 8-bit pass.
        send(8'hA5, 4'd8, 4'd0);
        chk("rst c1", EXP_ONE);
        step(); chk("rst c2", EXP_ZERO);
        step(); chk("rst c3", EXP_ONE);
        #3;
        reset = 1'b1;
        #1;
        chk("rst async", EXP_IDLE);
        step();
        step();
        #2;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("rst quiet %0d", k), EXP_IDLE);
        end
        run_vec(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
